// File: rtl/csa_pipe_pkg.sv
// Shared sizing helpers for the pipelined carry-select adder.
package csa_pipe_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int BLK_DEF   = 4;
   localparam int NSTG_DEF  = 2;

   // Bits of the carry chain resolved in one pipeline stage.
   function automatic int w_s(input int width, input int nstg);
      return width / nstg;
   endfunction

   function automatic int nblk_s(input int width, input int blk, input int nstg);
      return (width / nstg) / blk;
   endfunction

   function automatic bit cfg_ok(input int width, input int blk, input int nstg);
      return (nstg >= 1) && (blk >= 1) && ((width % (blk * nstg)) == 0)
             && (nstg <= width / blk);
   endfunction

endpackage

// File: rtl/csa_blk.sv
// One carry-select block: both carry-in cases precomputed, incoming carry picks one.
module csa_blk #(
   parameter int BLK = 4
) (
   input  logic [BLK-1:0] a_i,
   input  logic [BLK-1:0] b_i,
   input  logic           cin_i,
   output logic [BLK-1:0] sum_o,
   output logic           cout_o
);

   logic [BLK-1:0] s0, s1;
   logic           c0, c1;

   assign {c0, s0} = {1'b0, a_i} + {1'b0, b_i};
   assign {c1, s1} = {1'b0, a_i} + {1'b0, b_i} + (BLK+1)'(1);

   // The only carry-dependent logic: the select mux.
   assign sum_o  = cin_i ? s1 : s0;
   assign cout_o = cin_i ? c1 : c0;

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor; carry chain split over NSTG elastic stages.
module csa_pipe_adder
   import csa_pipe_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLK   = BLK_DEF,
   parameter int NSTG  = NSTG_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int W_S    = w_s(WIDTH, NSTG);
   localparam int NBLK_S = nblk_s(WIDTH, BLK, NSTG);

   if (!cfg_ok(WIDTH, BLK, NSTG)) begin : g_cfg_err
      $error("csa_pipe_adder: WIDTH must be a multiple of BLK*NSTG and 1 <= NSTG <= WIDTH/BLK");
   end

   logic [WIDTH-1:0] bx;
   logic             c0;
   logic [NSTG-1:0]  vld, adv;

   assign bx = sub ? ~b : b;
   assign c0 = sub | cin;

   // A stage advances when it is empty or its successor advances.
   always_comb begin
      adv = '0;
      adv[NSTG-1] = ~vld[NSTG-1] | out_ready;
      for (int k = NSTG - 2; k >= 0; k--) begin
         adv[k] = ~vld[k] | adv[k+1];
      end
   end

   for (genvar k = 0; k < NSTG; k++) begin : g_stg
      localparam int LO = k * W_S;

      logic                     v_in, cy_in, am_in, bm_in, cy_d;
      logic [WIDTH-LO-1:0]      a_in, bx_in;
      logic [W_S-1:0]           ssl;
      logic [(k+1)*W_S-1:0]     sum_d, sum_q;
      logic                     vld_q, cy_q, am_q, bm_q;

      if (k == 0) begin : g_src
         assign v_in  = in_valid;
         assign a_in  = a;
         assign bx_in = bx;
         assign cy_in = c0;
         assign am_in = a[WIDTH-1];
         assign bm_in = bx[WIDTH-1];
         assign sum_d = ssl;
      end else begin : g_src
         assign v_in  = g_stg[k-1].vld_q;
         assign a_in  = g_stg[k-1].g_pass.a_q;
         assign bx_in = g_stg[k-1].g_pass.bx_q;
         assign cy_in = g_stg[k-1].cy_q;
         assign am_in = g_stg[k-1].am_q;
         assign bm_in = g_stg[k-1].bm_q;
         assign sum_d = {ssl, g_stg[k-1].sum_q};
      end

      // Carry ripples block-to-block through the select muxes only.
      for (genvar j = 0; j < NBLK_S; j++) begin : g_blk
         logic ci, co;
         if (j == 0) begin : g_ci
            assign ci = cy_in;
         end else begin : g_ci
            assign ci = g_blk[j-1].co;
         end
         csa_blk #(.BLK(BLK)) u_blk (
            .a_i   (a_in[j*BLK +: BLK]),
            .b_i   (bx_in[j*BLK +: BLK]),
            .cin_i (ci),
            .sum_o (ssl[j*BLK +: BLK]),
            .cout_o(co)
         );
      end

      assign cy_d   = g_blk[NBLK_S-1].co;
      assign vld[k] = vld_q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            am_q  <= 1'b0;
            bm_q  <= 1'b0;
            sum_q <= '0;
         end else if (adv[k]) begin
            vld_q <= v_in;
            if (v_in) begin
               cy_q  <= cy_d;
               am_q  <= am_in;
               bm_q  <= bm_in;
               sum_q <= sum_d;
            end
         end
      end

      // Operand bits of the slices still ahead travel with the partial result.
      if (k < NSTG - 1) begin : g_pass
         localparam int PW = WIDTH - (k + 1) * W_S;
         logic [PW-1:0] a_q, bx_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q  <= '0;
               bx_q <= '0;
            end else if (adv[k] && v_in) begin
               a_q  <= a_in[WIDTH-LO-1:W_S];
               bx_q <= bx_in[WIDTH-LO-1:W_S];
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = g_stg[NSTG-1].vld_q;
   assign sum       = g_stg[NSTG-1].sum_q;
   assign cout      = g_stg[NSTG-1].cy_q;
   assign ovf       = (g_stg[NSTG-1].am_q == g_stg[NSTG-1].bm_q)
                      & (sum[WIDTH-1] != g_stg[NSTG-1].am_q);

endmodule
